icache: RTL
===========

# icache

Direct-mapped instruction cache that answers the fetch stage's per-cycle instruction read request and stalls it on a miss. Hits are returned combinationally in the request cycle. A miss triggers a line fill from the byte-wide memory controller port, four bytes, little-endian. It sits between the fetch stage and the memory arbiter. Its `instruction_flag_o` low is the fetch stage's stall condition.

## Interface
- `INDEX_BITS`, default 8: line index width; 2^INDEX_BITS lines, one 32-bit word per line.
- `ADDR_WIDTH`, default 32: address width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `read_flag_i`  in  1  fetch stage requests an instruction this cycle.
- `read_addr_i`  in  ADDR_WIDTH  fetch address (pc); bits [1:0] ignored.
- `instruction_flag_o`  out  1  `instruction_o` valid for `read_addr_i` this cycle.
- `instruction_o`  out  32  instruction word; 0 when `instruction_flag_o`=0.
- `mem_req_o`  out  1  byte read request to memory controller.
- `mem_addr_o`  out  ADDR_WIDTH  byte address of current request.
- `mem_ack_i`  in  1  controller has accepted the request; `mem_data_i` holds the byte at `mem_addr_o` this cycle.
- `mem_data_i`  in  8  returned byte.

## Operation
- Address split:
  - idx = `read_addr_i`[INDEX_BITS+1:2].
  - tag = `read_addr_i`[ADDR_WIDTH-1:INDEX_BITS+2].
- Storage per line: valid bit, tag, 32-bit data.
- Hit is combinational and independent of FSM state: `read_flag_i` & valid[idx] & tag[idx]==tag.
  - Hit: `instruction_flag_o`=1, `instruction_o`=data[idx].
  - Otherwise both outputs are 0.
- Hits to other lines are served while a fill is in progress.
- FSM states: IDLE, FILL.
  - IDLE: on `read_flag_i` & miss, latch fill_addr = {`read_addr_i`[ADDR_WIDTH-1:2],2'b00} and clear cnt to 0. Go to FILL.
  - FILL: `mem_req_o`=1 and `mem_addr_o`=fill_addr+cnt, both driven from registers only.
  - FILL, each cycle with `mem_ack_i`=1: store `mem_data_i` into byte lane cnt of the fill buffer and increment cnt.
  - FILL, on the ack with cnt==3: write the line (data = buffer with byte 3 = `mem_data_i`, tag, valid=1). Return to IDLE.
  - FILL, `mem_ack_i`=0: hold address and cnt; no timeout.
- A started fill always completes, even if `read_addr_i` changes (branch redirect) or `read_flag_i` drops. The line is still written. The IDLE lookup then re-evaluates the current address.
- IDLE: `mem_req_o`=0, `mem_addr_o`=0.
- No write or invalidate path. Instruction memory is read-only for the cache's lifetime.

## Timing
- Reset, while `rst`=1 at an edge:
  - All valid bits cleared; state IDLE; cnt 0.
  - Combinationally while `rst`=1: `instruction_flag_o`=0, `instruction_o`=0, `mem_req_o`=0, `mem_addr_o`=0.
- Reset mid-fill aborts the fill. No line is written, and outstanding acks are ignored.
- Hit latency: 0 cycles (same cycle as request).
- Miss detected in cycle T (IDLE):
  - `mem_req_o` rises in T+1.
  - With back-to-back acks, acks arrive in T+1..T+4 and the line is written at the T+4 edge.
  - Hit is visible at T+5.
  - Each stall cycle on the memory port extends the fill by one cycle.
- The written line is not visible in the write cycle itself; lookup in that cycle still sees the old contents.
- An ack seen in IDLE is ignored.
- A new miss cannot start in the cycle FILL returns to IDLE. It starts at the earliest on the next IDLE cycle.
- Aliasing address (same idx, different tag) on a valid line: miss, and the fill overwrites the line.

## Test plan
- Reset, then `read_flag_i`=1, addr 0x0000_0100, memory bytes 0x13,0x05,0x10,0x00 at 0x100..0x103 with ack every cycle:
  - `mem_addr_o` = 0x100, 0x101, 0x102, 0x103 in cycles 1-4.
  - `instruction_flag_o`=1 with `instruction_o`=0x0010_0513 in cycle 5.
- Same address again after the fill: hit in the same cycle, no `mem_req_o`.
- Fill with `mem_ack_i` low for 3 cycles between bytes 1 and 2:
  - `mem_addr_o` holds 0x101+1.
  - The completed word is correct, and the hit appears 3 cycles later than the back-to-back case.
- Mid-fill redirect of `read_addr_i` from 0x100 to 0x200 (0x200 uncached):
  - The 0x100 fill completes.
  - A new fill of 0x200 begins in the first IDLE cycle, then hits.
  - A later access to 0x100 hits with no request.
- Alias 0x100 vs 0x100 + 2^(INDEX_BITS+2) (0x500 for INDEX_BITS=8): second access misses, refills and overwrites; returning to 0x100 misses again.
- Assert `rst` during FILL after 2 acks:
  - Next cycle `mem_req_o`=0.
  - A subsequent request to the same address misses and refetches from byte 0.
  - No reads are served from stale valid bits.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache. Hits are answered combinationally
// in the request cycle; a miss fills the line one byte at a time from the memory port.
module icache #(
    parameter int INDEX_BITS = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_flag_i,
    input  logic [ADDR_WIDTH-1:0] read_addr_i,
    output logic                  instruction_flag_o,
    output logic [31:0]           instruction_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_ack_i,
    input  logic [7:0]            mem_data_i
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;
    localparam int WADDR_W = ADDR_WIDTH - 2;

    typedef enum logic {IDLE, FILL} state_t;

    state_t               state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [WADDR_W-1:0]   fill_addr_q, fill_addr_d;
    logic [23:0]          buf_q, buf_d;
    logic                 line_we;

    logic [LINES-1:0]     valid_q;
    logic [TAG_W-1:0]     tag_q  [LINES];
    logic [31:0]          data_q [LINES];

    logic [INDEX_BITS-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0]      req_tag, fill_tag;
    logic                  hit;
    logic                  unused_addr_bits;

    // Word-aligned fetch: the two byte-offset bits play no part in the lookup.
    assign unused_addr_bits = ^read_addr_i[1:0];

    assign req_idx  = read_addr_i[INDEX_BITS+1:2];
    assign req_tag  = read_addr_i[ADDR_WIDTH-1:INDEX_BITS+2];
    assign fill_idx = fill_addr_q[INDEX_BITS-1:0];
    assign fill_tag = fill_addr_q[WADDR_W-1:INDEX_BITS];

    // Lookup ignores the FSM so other lines keep hitting during a fill.
    assign hit = !rst && read_flag_i && valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    assign instruction_flag_o = hit;
    assign instruction_o      = hit ? data_q[req_idx] : 32'h0;

    // fill_addr is word aligned, so fill_addr + cnt is a plain concatenation.
    assign mem_req_o  = !rst && (state_q == FILL);
    assign mem_addr_o = mem_req_o ? {fill_addr_q, cnt_q} : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            fill_addr_q <= '0;
            buf_q       <= 24'h0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_addr_q <= fill_addr_d;
            buf_q       <= buf_d;
            if (line_we) valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && line_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= {mem_data_i, buf_q};
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_addr_d = fill_addr_q;
        buf_d       = buf_q;
        line_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (read_flag_i && !hit) begin
                    fill_addr_d = read_addr_i[ADDR_WIDTH-1:2];
                    cnt_d       = 2'd0;
                    state_d     = FILL;
                end
            end
            FILL: begin
                // The last byte goes straight into the line; it never needs buffering.
                if (mem_ack_i) begin
                    cnt_d = cnt_q + 2'd1;
                    case (cnt_q)
                        2'd0: buf_d[7:0]   = mem_data_i;
                        2'd1: buf_d[15:8]  = mem_data_i;
                        2'd2: buf_d[23:16] = mem_data_i;
                        default: begin
                            line_we = 1'b1;
                            state_d = IDLE;
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
